// File: rtl/adc_uart_streamer_if.sv
// Sample-strobe and serial-status bundle of the ADC-to-UART streamer.
// The master drives ADC samples and strobes; the slave is the streamer.
interface adc_uart_streamer_if;
   logic [11:0] ldata;
   logic        lstrb;
   logic [11:0] rdata;
   logic        rstrb;
   logic        uart_tx;
   logic        overflow;
   logic        busy;

   modport master (output ldata, lstrb, rdata, rstrb, input uart_tx, overflow, busy);
   modport slave  (input ldata, lstrb, rdata, rstrb, output uart_tx, overflow, busy);
endinterface

// File: rtl/adc_uart_streamer.sv
// Pairs left/right 12-bit ADC samples, queues them in a FWFT FIFO and sends each
// pair as a 4-byte 8N1 frame (A5, L[11:4], {L[3:0],R[11:8]}, R[7:0]).
module adc_uart_streamer #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 3125000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic               clock,
   input  logic               reset,
   adc_uart_streamer_if.slave bus
);
   localparam int DIV   = CLOCK_FREQ / BAUD_RATE;
   localparam int DIV_W = $clog2(DIV);
   localparam int AW    = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic             lvalid_q, rvalid_q;
   logic [11:0]      lsamp_q, rsamp_q;
   logic [AW:0]      wptr_q, rptr_q;
   logic [23:0]      mem [FIFO_DEPTH];
   logic             overflow_q;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       byte_q, byte_d;
   logic [23:0]      word_q, word_d;
   logic             tx_q, tx_d;

   logic             push_req, push, pop, fifo_empty, fifo_full, div_last;
   logic [7:0]       cur_byte;

   assign push_req   = lvalid_q & rvalid_q;
   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the pair.
   assign push       = push_req & (~fifo_full | pop);
   assign div_last   = (div_q == DIV_W'(DIV - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         lsamp_q    <= '0;
         rsamp_q    <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (bus.lstrb) begin
            lvalid_q <= 1'b1;
            lsamp_q  <= bus.ldata;
         end else if (push_req) begin
            lvalid_q <= 1'b0;
         end
         if (bus.rstrb) begin
            rvalid_q <= 1'b1;
            rsamp_q  <= bus.rdata;
         end else if (push_req) begin
            rvalid_q <= 1'b0;
         end
         if (push)
            wptr_q <= wptr_q + (AW+1)'(1);
         if (pop)
            rptr_q <= rptr_q + (AW+1)'(1);
         if (push_req && !push)
            overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wptr_q[AW-1:0]] <= {lsamp_q, rsamp_q};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         word_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      word_d  = word_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               word_d  = mem[rptr_q[AW-1:0]];
               byte_d  = '0;
               bit_d   = '0;
               div_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (div_last) begin
               div_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DATA: begin
            if (div_last) begin
               div_d = '0;
               if (bit_q == 3'd7)
                  state_d = STOP;
               else
                  bit_d = bit_q + 3'd1;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: begin
            if (div_last) begin
               div_d = '0;
               if (byte_q != 2'd3) begin
                  byte_d  = byte_q + 2'd1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
      endcase
   end

   // Line level is computed from the next state so uart_tx leaves a flop aligned with it.
   always_comb begin
      case (byte_d)
         2'd0:    cur_byte = 8'hA5;
         2'd1:    cur_byte = word_d[23:16];
         2'd2:    cur_byte = word_d[15:8];
         default: cur_byte = word_d[7:0];
      endcase
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = cur_byte[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   assign bus.uart_tx  = tx_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = lvalid_q | rvalid_q | ~fifo_empty | (state_q != IDLE);
endmodule

// File: doc/adc_uart_streamer.md
ADC_UART_STREAMER -- requirements
Module: adc_uart_streamer

Interface
REQ-001 Parameter CLOCK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 3125000: UART bit rate; DIV = CLOCK_FREQ/BAUD_RATE, integer, rounded down, SHALL be >= 4.
REQ-003 Parameter FIFO_DEPTH, default 16: sample-pair FIFO depth, power of two, >= 2.
REQ-004 Port clock, input, 1: single system clock; all logic rising-edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port ldata, input, 12: left ADC sample, valid when lstrb=1.
REQ-007 Port lstrb, input, 1: single-cycle left-sample strobe.
REQ-008 Port rdata, input, 12: right ADC sample, valid when rstrb=1.
REQ-009 Port rstrb, input, 1: single-cycle right-sample strobe.
REQ-010 Port uart_tx, output, 1: 8N1 serial output, idle high.
REQ-011 Port overflow, output, 1: sticky, set when a sample pair is dropped.
REQ-012 Port busy, output, 1: high while any pair is pending, queued, or being transmitted.

Function
REQ-013 Pairing: lstrb latches ldata and sets lvalid; rstrb latches rdata and sets rvalid; both may assert in the same cycle.
REQ-014 A strobe on a channel whose valid flag is already set SHALL overwrite the latched sample; newest wins; no error.
REQ-015 When lvalid and rvalid are both set, the {L,R} pair SHALL be pushed into the FIFO on the next edge and both flags cleared on that edge; a strobe arriving in the push cycle SHALL be latched, and its flag left set.
REQ-016 Push with FIFO full: pair dropped, flags still cleared, overflow set to 1; overflow clears only on reset.
REQ-017 FIFO: FIFO_DEPTH x 24-bit, first-word fall-through; pointer wrap modulo FIFO_DEPTH; full/empty from an extra pointer bit; simultaneous push and pop when full SHALL succeed for both.
REQ-018 TX FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE: if FIFO non-empty, pop the head word, load byte index 0, go to START.
REQ-020 Frame: 4 bytes, in order 0xA5, L[11:4], {L[3:0],R[11:8]}, R[7:0].
REQ-021 Per byte: START drives 0 for DIV cycles; DATA drives bits 0..7, LSB first, DIV cycles each; STOP drives 1 for DIV cycles.
REQ-022 After STOP: if byte index < 3, increment it and enter START with no gap; otherwise go to IDLE; a new frame may start the cycle after IDLE is entered.
REQ-023 uart_tx SHALL be driven from a flop (glitch-free).
REQ-024 Latency: strobe completing a pair sampled at edge 0 with TX IDLE and FIFO empty -> push at edge 1 -> pop and uart_tx=0 at edge 2.
REQ-025 busy = lvalid | rvalid | FIFO non-empty | (state != IDLE), registered or combinational from flops only.
REQ-026 Frame duration = 40*DIV cycles; at defaults (DIV=16) that is 640 cycles, sustaining 50 kHz stereo.

Reset
REQ-027 On reset assertion, immediately and asynchronously: uart_tx=1, overflow=0, busy=0, state=IDLE, FIFO empty, lvalid=rvalid=0, bit and byte counters 0.
REQ-028 Reset mid-frame SHALL abort the frame; after release, no partial byte is resent and the line stays high until a new pair completes.
REQ-029 Strobes SHALL be ignored while reset=1.

Verification
REQ-030 lstrb and rstrb are pulsed in the same cycle with ldata=0xABC, rdata=0x123 -> uart_tx falls 2 edges later; decoded bytes are A5, AB, C1, 23; each bit is 16 cycles; the frame is 640 cycles; busy then falls.
REQ-031 lstrb with 0x111, then 5 cycles later lstrb with 0x222, then 3 cycles later rstrb with 0x333 -> exactly one frame A5, 22, 23, 33.
REQ-032 18 simultaneous L/R strobe pairs on consecutive cycles, values 0x000..0x011 -> frames for pairs 0..16 are emitted in order; pair 17 is dropped; overflow=1 and stays 1 until reset.
REQ-033 Reset asserted during the DATA bit 3 of byte 2 -> uart_tx=1 in the same cycle; overflow=0; no further output until a new pair is strobed; the next frame is correct.
REQ-034 Simultaneous push and pop when the FIFO is full (steady strobes at the frame rate with FIFO_DEPTH=2) -> no overflow; the output sequence matches the input order.
